// File: rtl/dmem_responder_if.sv
// Data-memory request bus between the memory stage (master) and the responder (slave).
// Request fields are held by the master until Done; all response fields are registered.
interface dmem_responder_if;
  logic        Rd;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        Err;
  logic [15:0] ReqCount;
  logic [15:0] HitCount;

  modport master (
    output Rd, Wr, Addr, DataIn,
    input  DataOut, Done, Stall, CacheHit, Err, ReqCount, HitCount
  );

  modport slave (
    input  Rd, Wr, Addr, DataIn,
    output DataOut, Done, Stall, CacheHit, Err, ReqCount, HitCount
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder backed by a word array, with a direct-mapped
// tag store that makes hits finish in one cycle and misses in MISS_LAT cycles.
module dmem_responder #(
  parameter int MEM_AW   = 10,
  parameter int LINES    = 8,
  parameter int MISS_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDXW  = $clog2(LINES);
  localparam int TAGW  = 16 - IDXW - 1;
  localparam int CNTW  = $clog2(MISS_LAT + 1);
  localparam int WORDS = 2 ** MEM_AW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT             state;
  logic [CNTW-1:0]   cnt;
  logic [15:1]       addrReg;
  logic [15:0]       dataReg;
  logic              wrReg;
  logic [LINES-1:0]  valid;
  logic [TAGW-1:0]   tagMem [LINES];
  logic [15:0]       mem [WORDS];

  logic              reqIn;
  logic              illegalIn;
  logic              hitIn;
  logic [IDXW-1:0]   idxIn;
  logic [TAGW-1:0]   tagIn;
  logic              hitAccess;
  logic              missDone;
  logic              doAccess;
  logic [15:1]       accAddr;
  logic              accWr;
  logic [15:0]       accData;
  logic [MEM_AW-1:0] memIdx;
  logic [IDXW-1:0]   missIdx;
  logic [TAGW-1:0]   missTag;

  // The array access happens on the edge that enters RESP: the acceptance edge for a hit,
  // the last WAIT edge for a miss, when only the latched copy of the request is trusted.
  always_comb begin
    reqIn     = bus.Rd | bus.Wr;
    illegalIn = (bus.Rd & bus.Wr) | bus.Addr[0];
    idxIn     = bus.Addr[IDXW:1];
    tagIn     = bus.Addr[15:IDXW+1];
    hitIn     = valid[idxIn] && (tagMem[idxIn] == tagIn);
    hitAccess = (state == IDLE) && reqIn && !illegalIn && hitIn;
    missDone  = (state == WAIT) && (cnt == CNTW'(1));
    doAccess  = hitAccess | missDone;
    accAddr   = missDone ? addrReg : bus.Addr[15:1];
    accWr     = missDone ? wrReg   : bus.Wr;
    accData   = missDone ? dataReg : bus.DataIn;
    memIdx    = accAddr[MEM_AW:1];
    missIdx   = addrReg[IDXW:1];
    missTag   = addrReg[15:IDXW+1];
  end

  // Array and tag contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (doAccess && accWr) begin
      mem[memIdx] <= accData;
    end
    if (missDone) begin
      tagMem[missIdx] <= missTag;
    end
  end

  // Request FSM with all bus outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addrReg      <= '0;
      dataReg      <= '0;
      wrReg        <= 1'b0;
      valid        <= '0;
      bus.Done     <= 1'b0;
      bus.Stall    <= 1'b0;
      bus.CacheHit <= 1'b0;
      bus.Err      <= 1'b0;
      bus.DataOut  <= '0;
      bus.ReqCount <= '0;
      bus.HitCount <= '0;
    end else begin
      bus.Done     <= 1'b0;
      bus.CacheHit <= 1'b0;
      bus.Err      <= 1'b0;
      case (state)
        IDLE: begin
          if (reqIn) begin
            addrReg <= bus.Addr[15:1];
            dataReg <= bus.DataIn;
            wrReg   <= bus.Wr;
            if (bus.ReqCount != 16'hFFFF) begin
              bus.ReqCount <= bus.ReqCount + 16'd1;
            end
            if (illegalIn) begin
              state    <= RESP;
              bus.Done <= 1'b1;
              bus.Err  <= 1'b1;
            end else if (hitIn) begin
              state        <= RESP;
              bus.Done     <= 1'b1;
              bus.CacheHit <= 1'b1;
              if (bus.HitCount != 16'hFFFF) begin
                bus.HitCount <= bus.HitCount + 16'd1;
              end
              if (!accWr) begin
                bus.DataOut <= mem[memIdx];
              end
            end else begin
              state     <= WAIT;
              bus.Stall <= 1'b1;
              cnt       <= CNTW'(MISS_LAT - 1);
            end
          end
        end
        WAIT: begin
          if (missDone) begin
            state          <= RESP;
            bus.Stall      <= 1'b0;
            bus.Done       <= 1'b1;
            valid[missIdx] <= 1'b1;
            if (!accWr) begin
              bus.DataOut <= mem[memIdx];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random requests scored
// against a transaction-level model of the memory contents and per-set line occupancy.
module tb_dmem_responder;

  localparam int MEM_AW   = 10;
  localparam int LINES    = 8;
  localparam int MISS_LAT = 4;
  localparam int WORDS    = 2 ** MEM_AW;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  dmem_responder_if bus ();

  dmem_responder #(.MEM_AW(MEM_AW), .LINES(LINES), .MISS_LAT(MISS_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which line (byte address / 16 for 8 sets) occupies each set, and known memory words.
  int          occ [LINES];
  logic [15:0] refMem [WORDS];
  bit          refKnown [WORDS];
  int          refReq;
  int          refHit;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearModelCache();
    for (int i = 0; i < LINES; i++) occ[i] = -1;
    refReq = 0;
    refHit = 0;
  endtask

  // One complete request: predict, drive in IDLE, follow it to Done, check, then release.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                               input logic [15:0] data);
    bit          illegal;
    bit          hit;
    bit          seen;
    bit          checkData;
    int          expLat;
    int          lat;
    int          word;
    int          setIdx;
    int          lineId;
    logic [15:0] expData;

    illegal = (rd && wr) || addr[0];
    word    = (int'(addr) / 2) % WORDS;
    setIdx  = (int'(addr) / 2) % LINES;
    lineId  = int'(addr) / (2 * LINES);
    hit     = !illegal && (occ[setIdx] == lineId);
    expLat  = (illegal || hit) ? 1 : MISS_LAT;
    if (refReq < 65535) refReq++;
    if (hit && refHit < 65535) refHit++;
    checkData = 1'b0;
    expData   = '0;
    if (!illegal) begin
      if (wr) begin
        refMem[word]   = data;
        refKnown[word] = 1'b1;
      end else if (refKnown[word]) begin
        checkData = 1'b1;
        expData   = refMem[word];
      end
      occ[setIdx] = lineId;
    end

    @(negedge clk);
    bus.Rd     = rd;
    bus.Wr     = wr;
    bus.Addr   = addr;
    bus.DataIn = data;
    @(posedge clk);

    seen = 1'b0;
    lat  = 0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.Done) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        checkOutput("stallWhileWaiting", bus.Stall, cyc < expLat);
        checkOutput("flagsWithoutDone", {bus.CacheHit, bus.Err}, 0);
      end
    end

    if (!seen) begin
      checkOutput("doneTimeout", 0, 1);
    end else begin
      checkOutput("latency", lat, expLat);
      checkOutput("cacheHit", bus.CacheHit, hit);
      checkOutput("err", bus.Err, illegal);
      checkOutput("stallAtDone", bus.Stall, 0);
      checkOutput("reqCount", bus.ReqCount, refReq);
      checkOutput("hitCount", bus.HitCount, refHit);
      if (checkData) checkOutput("dataOut", bus.DataOut, expData);
    end
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    for (int i = 0; i < WORDS; i++) refKnown[i] = 1'b0;
    clearModelCache();
    bus.Rd     = 1'b0;
    bus.Wr     = 1'b0;
    bus.Addr   = '0;
    bus.DataIn = '0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("resetDone", bus.Done, 0);
    checkOutput("resetStall", bus.Stall, 0);
    checkOutput("resetCacheHit", bus.CacheHit, 0);
    checkOutput("resetErr", bus.Err, 0);
    checkOutput("resetDataOut", bus.DataOut, 0);
    checkOutput("resetReqCount", bus.ReqCount, 0);
    checkOutput("resetHitCount", bus.HitCount, 0);
    rst = 1'b0;

    // Miss, hit, conflict eviction and illegal requests.
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0110, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h0010, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h0011, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Held read of a cached word: Done alternates, one acceptance per two cycles.
    @(negedge clk);
    bus.Rd   = 1'b1;
    bus.Wr   = 1'b0;
    bus.Addr = 16'h0010;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      checkOutput("backToBackDone", bus.Done, cyc % 2);
      if (bus.Done) begin
        checkOutput("backToBackHit", bus.CacheHit, 1);
        checkOutput("backToBackData", bus.DataOut, 16'h1234);
      end
    end
    bus.Rd = 1'b0;
    refReq += 4;
    refHit += 4;
    checkOutput("backToBackReqCount", bus.ReqCount, refReq);
    checkOutput("backToBackHitCount", bus.HitCount, refHit);

    // Reset during a write miss drops the write and clears the tag store.
    applyStimulus(1'b0, 1'b1, 16'h0020, 16'hAAAA);
    applyStimulus(1'b1, 1'b0, 16'h0120, 16'h0000);
    @(negedge clk);
    bus.Wr     = 1'b1;
    bus.Addr   = 16'h0020;
    bus.DataIn = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midMissStall1", bus.Stall, 1);
    @(negedge clk);
    checkOutput("midMissStall2", bus.Stall, 1);
    rst = 1'b1;
    #1;
    checkOutput("midResetStall", bus.Stall, 0);
    checkOutput("midResetDone", bus.Done, 0);
    checkOutput("midResetReqCount", bus.ReqCount, 0);
    checkOutput("midResetHitCount", bus.HitCount, 0);
    @(negedge clk);
    bus.Wr = 1'b0;
    rst    = 1'b0;
    clearModelCache();
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Random traffic over a few tags per set so conflicts and re-hits are frequent.
    for (int n = 0; n < 80; n++) begin
      bit          rd;
      bit          wr;
      int          kind;
      logic [15:0] addr;
      kind = int'($urandom_range(0, 9));
      rd   = (kind == 0) || (kind >= 5);
      wr   = (kind <= 4);
      addr = 16'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 7) << 1));
      if ($urandom_range(0, 9) == 0) addr[0] = 1'b1;
      applyStimulus(rd, wr, addr, 16'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
